// File: rtl/lock_actuator_ctrl_if.sv
// Result/lock signal bundle between the unlock-code detector side and lock_actuator_ctrl.
// The detector (master) drives the result strobe; the controller (slave) drives the lock outputs.
interface lock_actuator_ctrl_if #(
    parameter int MAX_FAILS = 3
);
    localparam int FC_W = $clog2(MAX_FAILS + 1);

    logic            res_val;
    logic            res_ok;
    logic            unlock;
    logic            lockout;
    logic            accept;
    logic [FC_W-1:0] fail_cnt;
    logic            alarm;

    modport master (
        output res_val, res_ok,
        input  unlock, lockout, accept, fail_cnt, alarm
    );

    modport slave (
        input  res_val, res_ok,
        output unlock, lockout, accept, fail_cnt, alarm
    );
endinterface

// File: rtl/lock_actuator_ctrl.sv
// Lock actuator: opens the solenoid on a correct code, times out a lockout after MAX_FAILS failures.
// Optional tamper/lockout alarm output is built only when LOCK_ALARM_EN is defined.
module lock_actuator_ctrl #(
    parameter int UNLOCK_CYCLES  = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input logic               clk,
    input logic               rst,
    lock_actuator_ctrl_if.slave bus
);
    localparam int MAX_WIN = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_WIN + 1);
    localparam int FC_W    = $clog2(MAX_FAILS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic              unlock_q, unlock_d;
    logic              lockout_q, lockout_d;
    logic              accept_q, accept_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fail_cnt_d = fail_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.res_val) begin
                    if (bus.res_ok) begin
                        state_d    = OPEN;
                        timer_d    = TMR_W'(UNLOCK_CYCLES - 1);
                        fail_cnt_d = '0;
                    end else if (int'(fail_cnt_q) + 1 >= MAX_FAILS) begin
                        state_d    = LOCKOUT;
                        timer_d    = TMR_W'(LOCKOUT_CYCLES - 1);
                        fail_cnt_d = FC_W'(MAX_FAILS);
                    end else begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                end
            end
            OPEN: begin
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            LOCKOUT: begin
                // Failure history is only cleared once the lockout has fully elapsed.
                if (timer_q == '0) begin
                    state_d    = IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                timer_d    = '0;
                fail_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop in step with state_q.
        unlock_d  = (state_d == OPEN);
        lockout_d = (state_d == LOCKOUT);
        accept_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            fail_cnt_q <= '0;
            unlock_q   <= 1'b0;
            lockout_q  <= 1'b0;
            accept_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_cnt_q <= fail_cnt_d;
            unlock_q   <= unlock_d;
            lockout_q  <= lockout_d;
            accept_q   <= accept_d;
        end
    end

    assign bus.unlock   = unlock_q;
    assign bus.lockout  = lockout_q;
    assign bus.accept   = accept_q;
    assign bus.fail_cnt = fail_cnt_q;

`ifdef LOCK_ALARM_EN
    logic alarm_q, alarm_d;

    // One pulse on lockout entry, plus one per result strobe arriving while locked out.
    always_comb begin
        alarm_d = ((state_q == IDLE) && (state_d == LOCKOUT)) ||
                  ((state_q == LOCKOUT) && bus.res_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) alarm_q <= 1'b0;
        else     alarm_q <= alarm_d;
    end

    assign bus.alarm = alarm_q;
`else
    assign bus.alarm = 1'b0;
`endif
endmodule

// File: tb/tb_lock_actuator_ctrl.sv
// Directed bench for lock_actuator_ctrl (default parameters 8 / 3 / 16).
// Alarm expectations follow LOCK_ALARM_EN as defined for the build.
module tb_lock_actuator_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

`ifdef LOCK_ALARM_EN
    localparam int ALARM_ON = 1;
`else
    localparam int ALARM_ON = 0;
`endif

    lock_actuator_ctrl_if #(.MAX_FAILS(3)) bus ();

    lock_actuator_ctrl #(
        .UNLOCK_CYCLES (8),
        .MAX_FAILS     (3),
        .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ok);
        bus.res_val = 1'b1;
        bus.res_ok  = ok;
        step();
        bus.res_val = 1'b0;
        bus.res_ok  = 1'b0;
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] exp_fc);
        chk({tag, "_unlock"},  bus.unlock,   0);
        chk({tag, "_lockout"}, bus.lockout,  0);
        chk({tag, "_accept"},  bus.accept,   1);
        chk({tag, "_failcnt"}, bus.fail_cnt, exp_fc);
        chk({tag, "_alarm"},   bus.alarm,    0);
    endtask

    // Measures how long unlock (which=0) or lockout (which=1) stays high, starting from
    // its first high cycle; optionally injects strobes on window cycles 2, 4 and 6.
    task automatic window(input string tag, input bit which, input bit inj,
                          input int exp_len, input int exp_fc, input int exp_alarms);
        int n = 0;
        int alarms = 0;
        int bad_fc = 0;
        int bad_acc = 0;
        while (((which ? bus.lockout : bus.unlock) === 1'b1) && n < 100) begin
            n++;
            if (bus.alarm === 1'b1) alarms++;
            if (bus.fail_cnt !== 2'(exp_fc)) bad_fc++;
            if (bus.accept !== 1'b0) bad_acc++;
            bus.res_val = inj && (n == 2 || n == 4 || n == 6);
            bus.res_ok  = (n != 4);
            step();
        end
        bus.res_val = 1'b0;
        bus.res_ok  = 1'b0;
        chk({tag, "_len"},    n,       exp_len);
        chk({tag, "_fc"},     bad_fc,  0);
        chk({tag, "_accept"}, bad_acc, 0);
        chk({tag, "_alarms"}, alarms,  exp_alarms);
        chk({tag, "_after_accept"}, bus.accept, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.res_val = 1'b0;
        bus.res_ok  = 1'b0;
        step();
        step();
        chk_idle("reset", 0);
        rst = 1'b0;
        step();

        // Correct code: 8-cycle unlock.
        pulse(1'b1);
        chk("open_unlock", bus.unlock, 1);
        chk("open_accept", bus.accept, 0);
        window("open1", 1'b0, 1'b0, 8, 0, 0);
        chk_idle("after_open1", 0);

        // Three spaced failures lead to lockout.
        pulse(1'b0);
        chk("fail1_cnt", bus.fail_cnt, 1);
        chk("fail1_lockout", bus.lockout, 0);
        chk("fail1_accept", bus.accept, 1);
        step(); step();
        pulse(1'b0);
        chk("fail2_cnt", bus.fail_cnt, 2);
        step(); step();
        pulse(1'b0);
        chk("fail3_lockout", bus.lockout, 1);
        chk("fail3_cnt", bus.fail_cnt, 3);
        chk("fail3_alarm", bus.alarm, ALARM_ON);
        window("lock1", 1'b1, 1'b0, 16, 3, ALARM_ON);
        chk_idle("after_lock1", 0);

        // Two back-to-back failures then a correct code clears the count.
        pulse(1'b0);
        pulse(1'b0);
        chk("b2b_cnt", bus.fail_cnt, 2);
        pulse(1'b1);
        chk("clear_cnt", bus.fail_cnt, 0);
        chk("clear_unlock", bus.unlock, 1);
        window("open2", 1'b0, 1'b0, 8, 0, 0);
        pulse(1'b0);
        chk("single_fail_cnt", bus.fail_cnt, 1);
        step();
        chk("single_fail_nolock", bus.lockout, 0);

        // Strobes during OPEN are ignored.
        pulse(1'b1);
        window("open_inj", 1'b0, 1'b1, 8, 0, 0);
        chk("open_inj_fc", bus.fail_cnt, 0);

        // Strobes during LOCKOUT are ignored except for tamper alarms.
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        chk("lock2_lockout", bus.lockout, 1);
        window("lock_inj", 1'b1, 1'b1, 16, 3, 4 * ALARM_ON);
        chk_idle("after_lock_inj", 0);

        // Result in the cycle unlock falls starts a fresh window.
        pulse(1'b1);
        window("open3", 1'b0, 1'b0, 8, 0, 0);
        pulse(1'b1);
        chk("edge_restart_unlock", bus.unlock, 1);
        window("open_edge", 1'b0, 1'b0, 8, 0, 0);

        // Asynchronous reset in OPEN cycle 4.
        pulse(1'b1);
        step(); step(); step();
        chk("pre_rst_unlock", bus.unlock, 1);
        #2 rst = 1'b1;
        #1;
        chk_idle("rst_open", 0);
        @(posedge clk); #1 rst = 1'b0;
        step();
        chk_idle("rst_open_hold", 0);
        pulse(1'b1);
        window("open_post_rst", 1'b0, 1'b0, 8, 0, 0);

        // Asynchronous reset in LOCKOUT cycle 10.
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        repeat (9) step();
        chk("pre_rst_lockout", bus.lockout, 1);
        #2 rst = 1'b1;
        #1;
        chk_idle("rst_lock", 0);
        @(posedge clk); #1 rst = 1'b0;
        step();
        chk_idle("rst_lock_hold", 0);
        pulse(1'b1);
        window("open_post_rst2", 1'b0, 1'b0, 8, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
